// File: rtl/xadac_pkg.sv
// Shared types for the xadac dispatch slice: transaction payloads, the id->unit
// table entry and the response produced for locally rejected decodes.
package xadac_pkg;

  localparam int IdWidth      = 3;
  localparam int NumIds       = 2 ** IdWidth;
  localparam int UnitSelWidth = 3;

  typedef logic [IdWidth-1:0]      IdT;
  typedef logic [UnitSelWidth-1:0] UnitSelT;

  typedef struct packed {
    logic    valid;
    UnitSelT unit;
  } DispEntryT;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
  } DecReqT;

  typedef struct packed {
    IdT         id;
    logic       accept;
    logic       rd_clobber;
    logic       vd_clobber;
    logic [1:0] rs_read;
    logic [2:0] vs_read;
  } DecRspT;

  typedef struct packed {
    IdT               id;
    logic [31:0]      instr;
    logic [1:0][31:0] rs_data;
  } ExeReqT;

  typedef struct packed {
    IdT          id;
    logic [31:0] rd_data;
    logic [63:0] vd_data;
  } ExeRspT;

  // Id is filled in from the reject register; everything else stays zero.
  localparam DecRspT RejectRsp = '0;

endpackage

// File: rtl/xadac_if.sv
// One xadac coprocessor port: decode and execute request/response channels,
// each a valid/ready handshake.
interface xadac_if;
  import xadac_pkg::*;

  logic   dec_req_valid;
  logic   dec_req_ready;
  DecReqT dec_req;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  DecRspT dec_rsp;
  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeReqT exe_req;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;
  ExeRspT exe_rsp;

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_rr_arb.sv
// Round-robin arbiter: search starts at a registered pointer, a grant stalled
// by the consumer is locked until it completes, pointer moves on handshake.
module xadac_rr_arb #(
  parameter  int N    = 2,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic            hold,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] lockIdx;
  logic            locked;
  logic            found;
  int              j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (locked && req[lockIdx]) begin
      gnt[lockIdx] = 1'b1;
      idx          = lockIdx;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (!found && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = IdxW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr     <= '0;
      locked  <= 1'b0;
      lockIdx <= '0;
    end else begin
      locked  <= hold;
      lockIdx <= idx;
      if (advance) ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/xadac_dispatch.sv
// Fans one core xadac port out to NumUnits execution units: decode by funct3,
// execute through an id->unit table, responses merged by round-robin.
module xadac_dispatch
  import xadac_pkg::*;
#(
  parameter int NumUnits = 4,
  parameter int SelLsb   = 12,
  parameter int SelWidth = 3
) (
  input  logic  clk,
  input  logic  rstn,
  xadac_if.slv  slv,
  xadac_if.mst  mst [NumUnits],
  output logic  unmapped
);

  localparam int DecN    = NumUnits + 1;
  localparam int DecIdxW = $clog2(DecN);
  localparam int ExeIdxW = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  logic [SelWidth-1:0]          sel;
  logic                         selOk;
  logic [2**SelWidth-1:0]       decReqRdy;
  logic [2**UnitSelWidth-1:0]   exeReqRdy;
  logic [NumUnits-1:0]          decRspValid;
  logic [NumUnits-1:0]          exeRspValid;
  DecRspT                       decRspArr [NumUnits];
  ExeRspT                       exeRspArr [NumUnits];
  DecRspT                       decRspMux;
  logic [DecN-1:0]              decGnt;
  logic [DecIdxW-1:0]           decIdx;
  logic [NumUnits-1:0]          exeGnt;
  logic [ExeIdxW-1:0]           exeIdx;
  logic                         rejValid;
  IdT                           rejId;
  DispEntryT                    dispTable [NumIds];
  DispEntryT                    entry;
  logic                         decReqHs;
  logic                         decRspHs;
  logic                         exeReqHs;

  assign sel   = slv.dec_req.instr[SelLsb +: SelWidth];
  assign selOk = int'(sel) < NumUnits;
  assign entry = dispTable[slv.exe_req.id];

  for (genvar i = 0; i < NumUnits; i++) begin : gUnit
    assign mst[i].dec_req       = slv.dec_req;
    assign mst[i].dec_req_valid = slv.dec_req_valid && selOk && (int'(sel) == i);
    assign decReqRdy[i]         = mst[i].dec_req_ready;
    assign decRspValid[i]       = mst[i].dec_rsp_valid;
    assign decRspArr[i]         = mst[i].dec_rsp;
    assign mst[i].dec_rsp_ready = decGnt[i] && slv.dec_rsp_ready;

    assign mst[i].exe_req       = slv.exe_req;
    assign mst[i].exe_req_valid = slv.exe_req_valid && entry.valid && (int'(entry.unit) == i);
    assign exeReqRdy[i]         = mst[i].exe_req_ready;
    assign exeRspValid[i]       = mst[i].exe_rsp_valid;
    assign exeRspArr[i]         = mst[i].exe_rsp;
    assign mst[i].exe_rsp_ready = exeGnt[i] && slv.exe_rsp_ready;
  end

  for (genvar i = NumUnits; i < 2**SelWidth; i++) begin : gDecPad
    assign decReqRdy[i] = 1'b0;
  end

  for (genvar i = NumUnits; i < 2**UnitSelWidth; i++) begin : gExePad
    assign exeReqRdy[i] = 1'b0;
  end

  // Out-of-range selects are absorbed by the single-entry reject register.
  assign slv.dec_req_ready = selOk ? decReqRdy[sel] : !rejValid;
  assign decReqHs          = slv.dec_req_valid && slv.dec_req_ready;
  assign decRspHs          = slv.dec_rsp_valid && slv.dec_rsp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rejValid <= 1'b0;
      rejId    <= '0;
    end else if (decReqHs && !selOk) begin
      rejValid <= 1'b1;
      rejId    <= slv.dec_req.id;
    end else if (decRspHs && decGnt[NumUnits]) begin
      rejValid <= 1'b0;
    end
  end

  xadac_rr_arb #(.N(DecN)) uDecArb (
    .clk     (clk),
    .rstn    (rstn),
    .req     ({rejValid, decRspValid}),
    .hold    (slv.dec_rsp_valid && !slv.dec_rsp_ready),
    .advance (decRspHs),
    .gnt     (decGnt),
    .idx     (decIdx)
  );

  always_comb begin
    decRspMux    = RejectRsp;
    decRspMux.id = rejId;
    for (int i = 0; i < NumUnits; i++) begin
      if (decGnt[i]) decRspMux = decRspArr[i];
    end
  end

  assign slv.dec_rsp_valid = |decGnt;
  assign slv.dec_rsp       = decRspMux;

  // Ids without a live table entry are swallowed here and flagged on unmapped.
  assign slv.exe_req_ready = entry.valid ? exeReqRdy[entry.unit] : 1'b1;
  assign exeReqHs          = slv.exe_req_valid && slv.exe_req_ready;
  assign unmapped          = slv.exe_req_valid && !entry.valid;

  xadac_rr_arb #(.N(NumUnits)) uExeArb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (exeRspValid),
    .hold    (slv.exe_rsp_valid && !slv.exe_rsp_ready),
    .advance (slv.exe_rsp_valid && slv.exe_rsp_ready),
    .gnt     (exeGnt),
    .idx     (exeIdx)
  );

  assign slv.exe_rsp_valid = |exeGnt;
  assign slv.exe_rsp       = exeRspArr[exeIdx];

  // The accept write is issued after the clear so it wins on a shared id.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NumIds; k++) dispTable[k] <= '0;
    end else begin
      if (exeReqHs && entry.valid) dispTable[slv.exe_req.id].valid <= 1'b0;
      if (decRspHs && !decGnt[NumUnits] && slv.dec_rsp.accept)
        dispTable[slv.dec_rsp.id] <= '{valid: 1'b1, unit: UnitSelT'(decIdx)};
    end
  end

endmodule

// File: tb/tb_xadac_dispatch.sv
// Scenario tasks plus a randomized decode/execute loop, checked against an
// id->unit map and round-robin pick model kept in the bench.
module tb_xadac_dispatch;
  import xadac_pkg::*;

  localparam int NumUnits = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic unmapped;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  xadac_if coreIf ();
  xadac_if unitIf [NumUnits] ();

  xadac_dispatch #(.NumUnits(NumUnits), .SelLsb(12), .SelWidth(3)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .slv      (coreIf),
    .mst      (unitIf),
    .unmapped (unmapped)
  );

  logic [3:0] uDecReqReady, uDecRspValid, uExeReqReady, uExeRspValid;
  DecRspT     uDecRsp [NumUnits];
  ExeRspT     uExeRsp [NumUnits];
  logic [3:0] oDecReqValid, oDecRspReady, oExeReqValid, oExeRspReady;
  DecReqT     oDecReq [NumUnits];
  ExeReqT     oExeReq [NumUnits];

  for (genvar g = 0; g < NumUnits; g++) begin : gConn
    assign unitIf[g].dec_req_ready = uDecReqReady[g];
    assign unitIf[g].dec_rsp_valid = uDecRspValid[g];
    assign unitIf[g].dec_rsp       = uDecRsp[g];
    assign unitIf[g].exe_req_ready = uExeReqReady[g];
    assign unitIf[g].exe_rsp_valid = uExeRspValid[g];
    assign unitIf[g].exe_rsp       = uExeRsp[g];
    assign oDecReqValid[g] = unitIf[g].dec_req_valid;
    assign oDecReq[g]      = unitIf[g].dec_req;
    assign oDecRspReady[g] = unitIf[g].dec_rsp_ready;
    assign oExeReqValid[g] = unitIf[g].exe_req_valid;
    assign oExeReq[g]      = unitIf[g].exe_req;
    assign oExeRspReady[g] = unitIf[g].exe_rsp_ready;
  end

  // Reference state: which unit owns each id, and where each merge resumes.
  bit mValid [NumIds];
  int mUnit  [NumIds];
  int mDecPtr;
  int mExePtr;

  function automatic int rrPick(input logic [7:0] v, input int n, input int ptr);
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] routeOf(input int id);
    return mValid[id] ? 4'(1 << mUnit[id]) : 4'b0000;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NumIds; k++) begin
      mValid[k] = 1'b0;
      mUnit[k]  = 0;
    end
    mDecPtr = 0;
    mExePtr = 0;
  endtask

  task automatic idle();
    coreIf.dec_req_valid = 1'b0;
    coreIf.dec_req       = '0;
    coreIf.dec_rsp_ready = 1'b0;
    coreIf.exe_req_valid = 1'b0;
    coreIf.exe_req       = '0;
    coreIf.exe_rsp_ready = 1'b0;
    uDecReqReady = '0;
    uDecRspValid = '0;
    uExeReqReady = '0;
    uExeRspValid = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendDec(input int sel, input int id);
    coreIf.dec_req_valid        = 1'b1;
    coreIf.dec_req.instr        = $urandom;
    coreIf.dec_req.instr[14:12] = 3'(sel);
    coreIf.dec_req.id           = IdT'(id);
  endtask

  task automatic test_reset();
    idle();
    modelReset();
    #2;
    checks++;
    if (oDecReqValid !== 4'b0 || oExeReqValid !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_req_valid: dec=%b exe=%b want 0000", oDecReqValid, oExeReqValid);
    end
    checks++;
    if (coreIf.dec_rsp_valid !== 1'b0 || coreIf.exe_rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp_valid: dec=%b exe=%b want 0", coreIf.dec_rsp_valid, coreIf.exe_rsp_valid);
    end
    checks++;
    if (unmapped !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_unmapped: got %b want 0", unmapped);
    end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_decode_exec();
    int w;
    sendDec(1, 3);
    uDecReqReady = 4'b1111;
    #1;
    checks++;
    if (oDecReqValid !== 4'b0010 || coreIf.dec_req_ready !== 1'b1 || oDecReq[1].id !== IdT'(3)) begin
      errors++;
      $display("[TB] FAIL dec_route: valid=%b ready=%b id=%0d want 0010/1/3", oDecReqValid, coreIf.dec_req_ready, oDecReq[1].id);
    end
    step();
    idle();
    uDecRsp[1]   = '{id: 3'd3, accept: 1'b1, rd_clobber: 1'b1, vd_clobber: 1'b0, rs_read: 2'b11, vs_read: 3'b010};
    uDecRspValid = 4'b0010;
    coreIf.dec_rsp_ready = 1'b1;
    #1;
    w = rrPick({4'b0, 1'b0, uDecRspValid}, NumUnits + 1, mDecPtr);
    checks++;
    if (coreIf.dec_rsp_valid !== 1'b1 || coreIf.dec_rsp !== uDecRsp[w] || oDecRspReady !== 4'(1 << w)) begin
      errors++;
      $display("[TB] FAIL dec_rsp_unit1: valid=%b rsp=%h rdy=%b want 1/%h/%b", coreIf.dec_rsp_valid, coreIf.dec_rsp, oDecRspReady, uDecRsp[w], 4'(1 << w));
    end
    step();
    mValid[3] = 1'b1;
    mUnit[3]  = w;
    mDecPtr   = (w + 1) % (NumUnits + 1);
    idle();
    coreIf.exe_req_valid      = 1'b1;
    coreIf.exe_req.id         = 3'd3;
    coreIf.exe_req.rs_data[0] = 32'h5;
    uExeReqReady = 4'b1111;
    #1;
    checks++;
    if (oExeReqValid !== routeOf(3) || oExeReq[1].rs_data[0] !== 32'h5 || unmapped !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exe_route_id3: valid=%b rs0=%h unmapped=%b want %b/5/0", oExeReqValid, oExeReq[1].rs_data[0], unmapped, routeOf(3));
    end
    step();
    mValid[3] = 1'b0;
    #1;
    checks++;
    if (oExeReqValid !== routeOf(3) || unmapped !== !mValid[3]) begin
      errors++;
      $display("[TB] FAIL exe_id3_cleared: valid=%b unmapped=%b want %b/1", oExeReqValid, unmapped, routeOf(3));
    end
    step();
    idle();
  endtask

  task automatic test_reject();
    DecRspT exp;
    sendDec(6, 2);
    uDecReqReady = 4'b1111;
    coreIf.dec_rsp_ready = 1'b0;
    #1;
    checks++;
    if (oDecReqValid !== 4'b0 || coreIf.dec_req_ready !== 1'b1 || coreIf.dec_rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rej_accept: mst=%b ready=%b rspv=%b want 0000/1/0", oDecReqValid, coreIf.dec_req_ready, coreIf.dec_rsp_valid);
    end
    step();
    sendDec(7, 6);
    exp    = '0;
    exp.id = 3'd2;
    #1;
    checks++;
    if (coreIf.dec_req_ready !== 1'b0 || coreIf.dec_rsp_valid !== 1'b1 || coreIf.dec_rsp !== exp) begin
      errors++;
      $display("[TB] FAIL rej_full: ready=%b rspv=%b rsp=%h want 0/1/%h", coreIf.dec_req_ready, coreIf.dec_rsp_valid, coreIf.dec_rsp, exp);
    end
    step();
    coreIf.dec_rsp_ready = 1'b1;
    #1;
    checks++;
    if (coreIf.dec_rsp_valid !== 1'b1 || coreIf.dec_rsp !== exp) begin
      errors++;
      $display("[TB] FAIL rej_held: rspv=%b rsp=%h want 1/%h", coreIf.dec_rsp_valid, coreIf.dec_rsp, exp);
    end
    step();
    mDecPtr = (rrPick(8'b1_0000, NumUnits + 1, mDecPtr) + 1) % (NumUnits + 1);
    #1;
    checks++;
    if (coreIf.dec_req_ready !== 1'b1 || coreIf.dec_rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rej_drained: ready=%b rspv=%b want 1/0", coreIf.dec_req_ready, coreIf.dec_rsp_valid);
    end
    step();
    coreIf.dec_req_valid = 1'b0;
    exp.id = 3'd6;
    #1;
    checks++;
    if (coreIf.dec_rsp_valid !== 1'b1 || coreIf.dec_rsp !== exp) begin
      errors++;
      $display("[TB] FAIL rej_second: rspv=%b rsp=%h want 1/%h", coreIf.dec_rsp_valid, coreIf.dec_rsp, exp);
    end
    step();
    mDecPtr = (rrPick(8'b1_0000, NumUnits + 1, mDecPtr) + 1) % (NumUnits + 1);
    idle();
    coreIf.exe_req_valid = 1'b1;
    coreIf.exe_req.id    = 3'd2;
    #1;
    checks++;
    if (unmapped !== !mValid[2] || oExeReqValid !== routeOf(2)) begin
      errors++;
      $display("[TB] FAIL rej_no_table: unmapped=%b mst=%b want 1/0000", unmapped, oExeReqValid);
    end
    step();
    idle();
  endtask

  task automatic test_unmapped();
    coreIf.exe_req_valid = 1'b1;
    coreIf.exe_req.id    = 3'd5;
    uExeReqReady = 4'b1111;
    #1;
    checks++;
    if (unmapped !== 1'b1 || coreIf.exe_req_ready !== 1'b1 || oExeReqValid !== 4'b0) begin
      errors++;
      $display("[TB] FAIL unmapped_id5: unmapped=%b ready=%b mst=%b want 1/1/0000", unmapped, coreIf.exe_req_ready, oExeReqValid);
    end
    step();
    coreIf.exe_req_valid = 1'b0;
    #1;
    checks++;
    if (unmapped !== 1'b0 || coreIf.exe_rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unmapped_pulse: unmapped=%b rspv=%b want 0/0", unmapped, coreIf.exe_rsp_valid);
    end
    idle();
  endtask

  task automatic test_exe_rr();
    int w;
    uExeRspValid = 4'b1101;
    coreIf.exe_rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (n == 3) uExeRspValid[0] = 1'b1;
      #1;
      w = rrPick({4'b0, uExeRspValid}, NumUnits, mExePtr);
      checks++;
      if (coreIf.exe_rsp_valid !== 1'b1 || coreIf.exe_rsp !== uExeRsp[w] || oExeRspReady !== 4'(1 << w)) begin
        errors++;
        $display("[TB] FAIL exe_rr_%0d: rsp id=%0d rdy=%b want id=%0d rdy=%b", n, coreIf.exe_rsp.id, oExeRspReady, uExeRsp[w].id, 4'(1 << w));
      end
      step();
      mExePtr = (w + 1) % NumUnits;
      uExeRspValid[w] = 1'b0;
    end
    idle();
  endtask

  task automatic test_exe_lock();
    int w;
    int lockW;
    bit rdy;
    lockW = -1;
    for (int n = 0; n < 6; n++) begin
      case (n)
        0:       begin uExeRspValid = 4'b1000; rdy = 1'b1; end
        1:       begin uExeRspValid = 4'b0010; rdy = 1'b0; end
        2, 3:    begin uExeRspValid = 4'b0011; rdy = 1'b0; end
        4:       begin uExeRspValid = 4'b0011; rdy = 1'b1; end
        default: begin uExeRspValid = 4'b0001; rdy = 1'b1; end
      endcase
      coreIf.exe_rsp_ready = rdy;
      #1;
      w = (lockW >= 0 && uExeRspValid[lockW]) ? lockW : rrPick({4'b0, uExeRspValid}, NumUnits, mExePtr);
      checks++;
      if (coreIf.exe_rsp !== uExeRsp[w] || oExeRspReady !== (rdy ? 4'(1 << w) : 4'b0)) begin
        errors++;
        $display("[TB] FAIL exe_lock_%0d: rsp id=%0d rdy=%b want id=%0d", n, coreIf.exe_rsp.id, oExeRspReady, uExeRsp[w].id);
      end
      step();
      lockW = rdy ? -1 : w;
      if (rdy) mExePtr = (w + 1) % NumUnits;
    end
    idle();
  endtask

  task automatic test_random();
    int sel, id, eid, w;
    bit acc;
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 7);
      id  = $urandom_range(0, NumIds - 1);
      acc = 1'($urandom_range(0, 1));
      sendDec(sel, id);
      uDecReqReady = 4'b1111;
      #1;
      checks++;
      if (oDecReqValid !== (sel < NumUnits ? 4'(1 << sel) : 4'b0) || coreIf.dec_req_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rnd_dec_route_%0d: mst=%b ready=%b sel=%0d", n, oDecReqValid, coreIf.dec_req_ready, sel);
      end
      step();
      idle();
      if (sel < NumUnits) begin
        uDecRsp[sel]        = DecRspT'({$urandom, $urandom});
        uDecRsp[sel].id     = IdT'(id);
        uDecRsp[sel].accept = acc;
        uDecRspValid[sel]   = 1'b1;
      end
      coreIf.dec_rsp_ready = 1'b1;
      #1;
      w = rrPick({3'b0, sel >= NumUnits, uDecRspValid}, NumUnits + 1, mDecPtr);
      checks++;
      if (coreIf.dec_rsp_valid !== 1'b1 || coreIf.dec_rsp.id !== IdT'(id) ||
          coreIf.dec_rsp.accept !== (w < NumUnits && acc)) begin
        errors++;
        $display("[TB] FAIL rnd_dec_rsp_%0d: v=%b id=%0d acc=%b want 1/%0d/%b", n, coreIf.dec_rsp_valid, coreIf.dec_rsp.id, coreIf.dec_rsp.accept, id, w < NumUnits && acc);
      end
      step();
      mDecPtr = (w + 1) % (NumUnits + 1);
      if (w < NumUnits && acc) begin
        mValid[id] = 1'b1;
        mUnit[id]  = w;
      end
      idle();
      eid = $urandom_range(0, NumIds - 1);
      coreIf.exe_req_valid = 1'b1;
      coreIf.exe_req       = ExeReqT'({$urandom, $urandom, $urandom});
      coreIf.exe_req.id    = IdT'(eid);
      uExeReqReady = 4'b1111;
      #1;
      checks++;
      if (oExeReqValid !== routeOf(eid) || unmapped !== !mValid[eid]) begin
        errors++;
        $display("[TB] FAIL rnd_exe_route_%0d: mst=%b unmapped=%b want %b/%b", n, oExeReqValid, unmapped, routeOf(eid), !mValid[eid]);
      end
      step();
      mValid[eid] = 1'b0;
      idle();
    end
  endtask

  task automatic test_write_clear();
    sendDec(0, 7);
    uDecReqReady = 4'b0001;
    step();
    idle();
    uDecRsp[0]   = '{id: 3'd7, accept: 1'b1, default: '0};
    uDecRspValid = 4'b0001;
    coreIf.dec_rsp_ready = 1'b1;
    step();
    mDecPtr   = 1;
    mValid[7] = 1'b1;
    mUnit[7]  = 0;
    idle();
    coreIf.exe_req_valid = 1'b1;
    coreIf.exe_req.id    = 3'd7;
    uExeReqReady = 4'b1111;
    uDecRsp[2]   = '{id: 3'd7, accept: 1'b1, default: '0};
    uDecRspValid = 4'b0100;
    coreIf.dec_rsp_ready = 1'b1;
    #1;
    checks++;
    if (oExeReqValid !== routeOf(7) || coreIf.dec_rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wc_same_cycle: mst=%b rspv=%b want %b/1", oExeReqValid, coreIf.dec_rsp_valid, routeOf(7));
    end
    step();
    mValid[7] = 1'b0;
    mValid[7] = 1'b1;
    mUnit[7]  = 2;
    mDecPtr   = 3;
    uDecRspValid = 4'b0;
    coreIf.dec_rsp_ready = 1'b0;
    #1;
    checks++;
    if (oExeReqValid !== routeOf(7) || unmapped !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wc_write_wins: mst=%b unmapped=%b want %b/0", oExeReqValid, unmapped, routeOf(7));
    end
    step();
    mValid[7] = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid();
    int w;
    sendDec(2, 4);
    uDecReqReady = 4'b0100;
    step();
    idle();
    uDecRsp[2]   = '{id: 3'd4, accept: 1'b1, default: '0};
    uDecRspValid = 4'b0100;
    coreIf.dec_rsp_ready = 1'b1;
    uExeRspValid = 4'b0100;
    coreIf.exe_rsp_ready = 1'b1;
    step();
    mValid[4] = 1'b1;
    mUnit[4]  = 2;
    idle();
    coreIf.exe_req_valid = 1'b1;
    coreIf.exe_req.id    = 3'd4;
    #1;
    checks++;
    if (oExeReqValid !== routeOf(4)) begin
      errors++;
      $display("[TB] FAIL rm_pre_route: mst=%b want %b", oExeReqValid, routeOf(4));
    end
    rstn = 1'b0;
    modelReset();
    #2;
    checks++;
    if (oExeReqValid !== routeOf(4) || unmapped !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_async_clear: mst=%b unmapped=%b want 0000/1", oExeReqValid, unmapped);
    end
    step();
    rstn = 1'b1;
    step();
    checks++;
    if (unmapped !== !mValid[4] || coreIf.exe_req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_unmapped: unmapped=%b ready=%b want 1/1", unmapped, coreIf.exe_req_ready);
    end
    idle();
    uDecRsp[1] = '{id: 3'd1, default: '0};
    uDecRsp[3] = '{id: 3'd5, default: '0};
    uDecRspValid = 4'b1010;
    uExeRspValid = 4'b1010;
    #1;
    w = rrPick({4'b0, uExeRspValid}, NumUnits, mExePtr);
    checks++;
    if (coreIf.exe_rsp !== uExeRsp[w]) begin
      errors++;
      $display("[TB] FAIL rm_exe_ptr: rsp id=%0d want %0d", coreIf.exe_rsp.id, uExeRsp[w].id);
    end
    w = rrPick({4'b0, 1'b0, uDecRspValid}, NumUnits + 1, mDecPtr);
    checks++;
    if (coreIf.dec_rsp !== uDecRsp[w]) begin
      errors++;
      $display("[TB] FAIL rm_dec_ptr: rsp id=%0d want %0d", coreIf.dec_rsp.id, uDecRsp[w].id);
    end
    step();
    idle();
  endtask

  initial begin
    for (int i = 0; i < NumUnits; i++) begin
      uDecRsp[i] = '0;
      uExeRsp[i] = '{id: IdT'(i), rd_data: 32'hA0 + i, vd_data: {$urandom, $urandom}};
    end
    test_reset();
    test_decode_exec();
    test_reject();
    test_unmapped();
    test_exe_rr();
    test_exe_lock();
    test_random();
    test_write_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
